// File: rtl/sync_pkg.sv
// Shared helpers for the Gray-pointer synchronisers: width-generic Gray decode and multi-bit test.
package sync_pkg;

    localparam int MIN_STAGES    = 2;
    localparam int MAX_PTR_WIDTH = 64;

    typedef logic [MAX_PTR_WIDTH-1:0] ptr_max_t;

    // Narrower pointers are zero-extended by the caller; leading zeros leave the low bits' decode unchanged.
    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
        for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic multi_bit(input ptr_max_t diff);
        return (diff & (diff - ptr_max_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/sync_ptr_chan.sv
// One channel: STAGES-deep Gray synchroniser, registered binary decode, update strobe, sticky coherence error.
// Latency: STAGES edges to ptr_sync, STAGES+1 to ptr_bin/ptr_upd/gray_err; no backpressure, samples every edge.
module sync_ptr_chan
    import sync_pkg::*;
#(
    parameter int PTR_WIDTH = 8,
    parameter int STAGES    = 2
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic [PTR_WIDTH-1:0] ptr_in,
    input  logic                 err_clr,
    output logic [PTR_WIDTH-1:0] ptr_sync,
    output logic [PTR_WIDTH-1:0] ptr_bin,
    output logic                 ptr_upd,
    output logic                 gray_err
);

    // Only this stage sees the asynchronous input.
    (* ASYNC_REG = "TRUE" *) logic [PTR_WIDTH-1:0] meta_q;
    logic [PTR_WIDTH-1:0] meta_d;
    logic [PTR_WIDTH-1:0] chain_q [1:STAGES-1];
    logic [PTR_WIDTH-1:0] chain_d [1:STAGES-1];
    logic [PTR_WIDTH-1:0] prev_q, prev_d;
    logic [PTR_WIDTH-1:0] bin_q, bin_d;
    logic                 upd_q, upd_d;
    logic                 err_q, err_d;

    assign ptr_sync = chain_q[STAGES-1];
    assign ptr_bin  = bin_q;
    assign ptr_upd  = upd_q;
    assign gray_err = err_q;

    always_comb begin
        meta_d     = ptr_in;
        chain_d[1] = meta_q;
        for (int k = 2; k < STAGES; k++) begin
            chain_d[k] = chain_q[k-1];
        end
        prev_d = ptr_sync;
        bin_d  = PTR_WIDTH'(gray2bin(ptr_max_t'(ptr_sync)));
        upd_d  = (ptr_sync != prev_q);
        // A fresh violation wins over a clear in the same cycle.
        if (multi_bit(ptr_max_t'(ptr_sync ^ prev_q))) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            meta_q <= '0;
            for (int k = 1; k < STAGES; k++) begin
                chain_q[k] <= '0;
            end
            prev_q <= '0;
            bin_q  <= '0;
            upd_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            for (int k = 1; k < STAGES; k++) begin
                chain_q[k] <= chain_d[k];
            end
            prev_q <= prev_d;
            bin_q  <= bin_d;
            upd_q  <= upd_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/sync_ptr_multi.sv
// Multi-channel Gray-pointer synchroniser in the destination domain; channels are fully independent.
// Latency: STAGES edges to ptr_sync, STAGES+1 to ptr_bin/ptr_upd/gray_err; no backpressure, samples every edge.
module sync_ptr_multi
    import sync_pkg::*;
#(
    parameter int PTR_WIDTH = 8,
    parameter int STAGES    = 2,
    parameter int CHANNELS  = 1
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [CHANNELS*PTR_WIDTH-1:0] ptr_in,
    input  logic [CHANNELS-1:0]           err_clr,
    output logic [CHANNELS*PTR_WIDTH-1:0] ptr_sync,
    output logic [CHANNELS*PTR_WIDTH-1:0] ptr_bin,
    output logic [CHANNELS-1:0]           ptr_upd,
    output logic [CHANNELS-1:0]           gray_err
);

    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("sync_ptr_multi: STAGES must be at least %0d", MIN_STAGES);
    end
    if (PTR_WIDTH < 2 || PTR_WIDTH > MAX_PTR_WIDTH) begin : g_bad_width
        $error("sync_ptr_multi: PTR_WIDTH must be 2..%0d", MAX_PTR_WIDTH);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        sync_ptr_chan #(
            .PTR_WIDTH (PTR_WIDTH),
            .STAGES    (STAGES)
        ) u_chan (
            .wclk     (wclk),
            .wrst     (wrst),
            .ptr_in   (ptr_in[c*PTR_WIDTH +: PTR_WIDTH]),
            .err_clr  (err_clr[c]),
            .ptr_sync (ptr_sync[c*PTR_WIDTH +: PTR_WIDTH]),
            .ptr_bin  (ptr_bin[c*PTR_WIDTH +: PTR_WIDTH]),
            .ptr_upd  (ptr_upd[c]),
            .gray_err (gray_err[c])
        );
    end

endmodule

// File: tb/tb_sync_ptr_multi.sv
// Directed bench for sync_ptr_multi: a hand-computed vector table on a 3-channel instance plus Gray sweeps on three configurations.
module tb_sync_ptr_multi;

    logic wclk = 1'b0;
    always #5 wclk = ~wclk;

    logic wrst;

    // Main instance: PTR_WIDTH=4, STAGES=3, CHANNELS=3
    logic [11:0] ptr_in_m, ptr_sync_m, ptr_bin_m;
    logic [2:0]  err_clr_m, ptr_upd_m, gray_err_m;
    // Corner A: PTR_WIDTH=2, STAGES=2
    logic [1:0]  ptr_in_a, ptr_sync_a, ptr_bin_a;
    logic        err_clr_a, ptr_upd_a, gray_err_a;
    // Corner B: PTR_WIDTH=12, STAGES=5
    logic [11:0] ptr_in_b, ptr_sync_b, ptr_bin_b;
    logic        err_clr_b, ptr_upd_b, gray_err_b;

    sync_ptr_multi #(.PTR_WIDTH(4), .STAGES(3), .CHANNELS(3)) u_dut_m (
        .wclk(wclk), .wrst(wrst), .ptr_in(ptr_in_m), .err_clr(err_clr_m),
        .ptr_sync(ptr_sync_m), .ptr_bin(ptr_bin_m), .ptr_upd(ptr_upd_m), .gray_err(gray_err_m));

    sync_ptr_multi #(.PTR_WIDTH(2), .STAGES(2), .CHANNELS(1)) u_dut_a (
        .wclk(wclk), .wrst(wrst), .ptr_in(ptr_in_a), .err_clr(err_clr_a),
        .ptr_sync(ptr_sync_a), .ptr_bin(ptr_bin_a), .ptr_upd(ptr_upd_a), .gray_err(gray_err_a));

    sync_ptr_multi #(.PTR_WIDTH(12), .STAGES(5), .CHANNELS(1)) u_dut_b (
        .wclk(wclk), .wrst(wrst), .ptr_in(ptr_in_b), .err_clr(err_clr_b),
        .ptr_sync(ptr_sync_b), .ptr_bin(ptr_bin_b), .ptr_upd(ptr_upd_b), .gray_err(gray_err_b));

    typedef struct {
        logic        rst;
        logic [11:0] ptr;
        logic [2:0]  clr;
        logic [11:0] e_sync;
        logic [11:0] e_bin;
        logic [2:0]  e_upd;
        logic [2:0]  e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [11:0] ptr, input logic [2:0] clr,
                       input logic [11:0] e_sync, input logic [11:0] e_bin,
                       input logic [2:0] e_upd, input logic [2:0] e_err);
        vec_t v;
        v.rst = rst; v.ptr = ptr; v.clr = clr;
        v.e_sync = e_sync; v.e_bin = e_bin; v.e_upd = e_upd; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic drive(input int which, input logic [11:0] g);
        case (which)
            0:       ptr_in_m = {8'h00, g[3:0]};
            1:       ptr_in_a = g[1:0];
            default: ptr_in_b = g;
        endcase
    endtask

    task automatic sample(input int which, output logic [11:0] sync, output logic [11:0] bin,
                          output logic upd, output logic err);
        case (which)
            0: begin
                sync = {8'h00, ptr_sync_m[3:0]}; bin = {8'h00, ptr_bin_m[3:0]};
                upd = ptr_upd_m[0]; err = gray_err_m[0];
            end
            1: begin
                sync = {10'h000, ptr_sync_a}; bin = {10'h000, ptr_bin_a};
                upd = ptr_upd_a; err = gray_err_a;
            end
            default: begin
                sync = ptr_sync_b; bin = ptr_bin_b; upd = ptr_upd_b; err = gray_err_b;
            end
        endcase
    endtask

    // Steps through every Gray code (ending on the wrap back to 0), holding each for STAGES+2 edges.
    task automatic sweep(input int which, input int w, input int stages);
        int          n;
        int          hold;
        int          v;
        int          lat;
        int          pulses;
        logic [11:0] g, s_sync, s_bin;
        logic        s_upd, s_err;
        n    = 1 << w;
        hold = stages + 2;
        wrst = 1'b1;
        drive(which, 12'h000);
        @(posedge wclk); #1;
        wrst = 1'b0;
        for (int i = 1; i <= n; i++) begin
            v = i % n;
            g = 12'(v ^ (v >> 1));
            drive(which, g);
            lat    = 0;
            pulses = 0;
            for (int e = 1; e <= hold; e++) begin
                @(posedge wclk); #1;
                sample(which, s_sync, s_bin, s_upd, s_err);
                if (s_upd) begin
                    pulses++;
                    lat = e;
                end
            end
            chk($sformatf("sweep%0d_step%0d_sync", which, i), 32'(s_sync), 32'(g));
            chk($sformatf("sweep%0d_step%0d_bin", which, i), 32'(s_bin), 32'(v));
            chk($sformatf("sweep%0d_step%0d_err", which, i), 32'(s_err), 32'd0);
            chk($sformatf("sweep%0d_step%0d_pulses", which, i), 32'(pulses), 32'd1);
            chk($sformatf("sweep%0d_step%0d_latency", which, i), 32'(lat), 32'(stages + 1));
        end
    endtask

    initial begin
        wrst      = 1'b1;
        ptr_in_m  = '0; err_clr_m = '0;
        ptr_in_a  = '0; err_clr_a = 1'b0;
        ptr_in_b  = '0; err_clr_b = 1'b0;

        //  rst  ptr      clr    sync     bin      upd    err
        add(1, 12'h000, 3'd0, 12'h000, 12'h000, 3'd0, 3'd0);
        add(1, 12'h000, 3'd0, 12'h000, 12'h000, 3'd0, 3'd0);
        // ch0 0000 -> 0011: latency plus a two-bit coherence violation
        add(0, 12'h003, 3'd0, 12'h000, 12'h000, 3'd0, 3'd0);
        add(0, 12'h003, 3'd0, 12'h000, 12'h000, 3'd0, 3'd0);
        add(0, 12'h003, 3'd0, 12'h003, 12'h000, 3'd0, 3'd0);
        add(0, 12'h003, 3'd0, 12'h003, 12'h002, 3'd1, 3'd1);
        add(0, 12'h003, 3'd0, 12'h003, 12'h002, 3'd0, 3'd1);
        add(0, 12'h003, 3'd1, 12'h003, 12'h002, 3'd0, 3'd0);
        add(0, 12'h003, 3'd0, 12'h003, 12'h002, 3'd0, 3'd0);
        // ch0 0011 -> 0000 with err_clr coinciding with detection: set wins
        add(0, 12'h000, 3'd0, 12'h003, 12'h002, 3'd0, 3'd0);
        add(0, 12'h000, 3'd0, 12'h003, 12'h002, 3'd0, 3'd0);
        add(0, 12'h000, 3'd0, 12'h000, 12'h002, 3'd0, 3'd0);
        add(0, 12'h000, 3'd1, 12'h000, 12'h000, 3'd1, 3'd1);
        add(0, 12'h000, 3'd0, 12'h000, 12'h000, 3'd0, 3'd1);
        // ch1 alone: 0000 -> 0001 -> 0011
        add(0, 12'h010, 3'd0, 12'h000, 12'h000, 3'd0, 3'd1);
        add(0, 12'h010, 3'd0, 12'h000, 12'h000, 3'd0, 3'd1);
        add(0, 12'h010, 3'd0, 12'h010, 12'h000, 3'd0, 3'd1);
        add(0, 12'h010, 3'd0, 12'h010, 12'h010, 3'd2, 3'd1);
        add(0, 12'h030, 3'd0, 12'h010, 12'h010, 3'd0, 3'd1);
        add(0, 12'h030, 3'd0, 12'h010, 12'h010, 3'd0, 3'd1);
        add(0, 12'h030, 3'd0, 12'h030, 12'h010, 3'd0, 3'd1);
        add(0, 12'h030, 3'd0, 12'h030, 12'h020, 3'd2, 3'd1);
        add(0, 12'h030, 3'd0, 12'h030, 12'h020, 3'd0, 3'd1);
        // ch0 -> 0110 with error still set, then one-cycle reset (err_clr ignored under reset)
        add(0, 12'h036, 3'd0, 12'h030, 12'h020, 3'd0, 3'd1);
        add(0, 12'h036, 3'd0, 12'h030, 12'h020, 3'd0, 3'd1);
        add(0, 12'h036, 3'd0, 12'h036, 12'h020, 3'd0, 3'd1);
        add(0, 12'h036, 3'd0, 12'h036, 12'h024, 3'd1, 3'd1);
        add(0, 12'h036, 3'd0, 12'h036, 12'h024, 3'd0, 3'd1);
        add(1, 12'h036, 3'd1, 12'h000, 12'h000, 3'd0, 3'd0);
        add(0, 12'h036, 3'd0, 12'h000, 12'h000, 3'd0, 3'd0);
        add(0, 12'h036, 3'd0, 12'h000, 12'h000, 3'd0, 3'd0);
        add(0, 12'h036, 3'd0, 12'h036, 12'h000, 3'd0, 3'd0);
        add(0, 12'h036, 3'd0, 12'h036, 12'h024, 3'd3, 3'd3);
        add(0, 12'h036, 3'd0, 12'h036, 12'h024, 3'd0, 3'd3);
        add(0, 12'h036, 3'd3, 12'h036, 12'h024, 3'd0, 3'd0);

        for (int r = 0; r < vecs.size(); r++) begin
            wrst      = vecs[r].rst;
            ptr_in_m  = vecs[r].ptr;
            err_clr_m = vecs[r].clr;
            @(posedge wclk); #1;
            chk($sformatf("row%0d_sync", r), 32'(ptr_sync_m), 32'(vecs[r].e_sync));
            chk($sformatf("row%0d_bin", r), 32'(ptr_bin_m), 32'(vecs[r].e_bin));
            chk($sformatf("row%0d_upd", r), 32'(ptr_upd_m), 32'(vecs[r].e_upd));
            chk($sformatf("row%0d_err", r), 32'(gray_err_m), 32'(vecs[r].e_err));
        end
        wrst      = 1'b0;
        err_clr_m = '0;

        sweep(0, 4, 3);
        sweep(1, 2, 2);
        sweep(2, 12, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
